// File: rtl/sram_fifo_ctrl_if.sv
// Handshake and SRAM bus bundle for sram_fifo_ctrl.
// The slave side is the FIFO controller; the master side is the producer, consumer and SRAM macro.
interface sram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  flush;
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_ready;
    logic [ADDR_WIDTH:0]   count;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;
    logic                  sram_wEn;
    logic [ADDR_WIDTH-1:0] sram_wAddr;
    logic [DATA_WIDTH-1:0] sram_dIn;
    logic [ADDR_WIDTH-1:0] sram_rAddr;
    logic [DATA_WIDTH-1:0] sram_dOut;

    modport slave (
        input  flush, wr_valid, wr_data, rd_ready, sram_dOut,
        output wr_ready, rd_valid, rd_data, count, almost_full, overflow, underflow,
               sram_wEn, sram_wAddr, sram_dIn, sram_rAddr
    );

    modport master (
        output flush, wr_valid, wr_data, rd_ready, sram_dOut,
        input  wr_ready, rd_valid, rd_data, count, almost_full, overflow, underflow,
               sram_wEn, sram_wAddr, sram_dIn, sram_rAddr
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// Show-ahead FIFO controller around an external two-port SRAM with asynchronous read.
// Holds the wrap-bit pointers, occupancy and sticky error flags; the SRAM stores the data.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 1
) (
    input  logic              clock,
    input  logic              reset,
    sram_fifo_ctrl_if.slave   bus
);
    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] AFULL_THR = PTR_W'(AFULL_LVL);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      count_q;
    logic [PTR_W-1:0]      count_next;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  empty;
    logic                  full;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;

    // The wrap bit tells full (same address, opposite lap) from empty (same address, same lap).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    assign wr_fire = bus.wr_valid & ~full;
    assign rd_fire = bus.rd_ready & ~empty;

    assign wr_data = bus.wr_data;
    assign rd_data = bus.sram_dOut;

    assign bus.sram_wEn    = wr_fire;
    assign bus.sram_wAddr  = wr_ptr[ADDR_WIDTH-1:0];
    assign bus.sram_dIn    = wr_data;
    assign bus.sram_rAddr  = rd_ptr[ADDR_WIDTH-1:0];
    assign bus.rd_data     = rd_data;
    assign bus.wr_ready    = ~full;
    assign bus.rd_valid    = ~empty;
    assign bus.count       = count_q;
    assign bus.almost_full = (count_q >= AFULL_THR);
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_next = count_q;
        unique case ({wr_fire, rd_fire})
            2'b10:   count_next = count_q + PTR_ONE;
            2'b01:   count_next = count_q - PTR_ONE;
            default: count_next = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_valid && full) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_ready && empty) begin
                underflow_q <= 1'b1;
            end
            // Flush discards any transfer that fires in the same cycle.
            if (bus.flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (wr_fire) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (rd_fire) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                count_q <= count_next;
            end
        end
    end
endmodule
